// File: rtl/idma_rd_burst_split.sv
// Splits one linear read descriptor into 4KB-safe AXI INCR bursts, one {addr, awlen} word per FIFO push.
// Latency: first push 2 cycles after accept, then one burst per 2 cycles; push is held off while fifo_full_s is high.
module idma_rd_burst_split #(
   parameter int unsigned BUS_BYTES = 8,
   parameter int unsigned MAX_BEATS = 16,
   parameter int unsigned LEN_WID   = 32
) (
   input  logic               clk_s,
   input  logic               rst_s,
   input  logic               desc_valid,
   output logic               desc_ready,
   input  logic [31:0]        desc_addr,
   input  logic [LEN_WID-1:0] desc_len,
   input  logic               abort,
   input  logic               fifo_full_s,
   output logic               fifo_push_s,
   output logic [63:0]        fifo_data_s,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [15:0]        burst_cnt
);
   localparam int unsigned OFF_W  = $clog2(BUS_BYTES);
   localparam int unsigned REM_W  = LEN_WID - OFF_W;
   localparam int unsigned BEAT_W = $clog2(MAX_BEATS) + 1;

   typedef enum logic [1:0] {IDLE, CALC, PUSH, DONE} state_t;

   state_t            state;
   logic [31:0]       cur_addr;
   logic [REM_W-1:0]  rem_beats;
   logic [BEAT_W-1:0] beats;
   logic [12:0]       to4k;
   logic [BEAT_W-1:0] cap;
   logic [BEAT_W-1:0] calc_beats;
   logic              misalign;
   logic              accept;
   logic              last_push;

   // Beats left before the next 4KB page, then the tightest of the three limits.
   always_comb begin
      to4k       = (13'd4096 - {1'b0, cur_addr[11:0]}) >> OFF_W;
      cap        = (rem_beats < REM_W'(MAX_BEATS)) ? rem_beats[BEAT_W-1:0] : BEAT_W'(MAX_BEATS);
      calc_beats = (13'(cap) < to4k) ? cap : to4k[BEAT_W-1:0];
   end

   assign accept      = (state == IDLE) && desc_ready && desc_valid;
   assign misalign    = (|desc_addr[OFF_W-1:0]) || (|desc_len[OFF_W-1:0]);
   assign last_push   = (rem_beats == REM_W'(beats));
   assign fifo_push_s = (state == PUSH) && !fifo_full_s;

   always_ff @(posedge clk_s or posedge rst_s) begin
      if (rst_s) begin
         state       <= IDLE;
         desc_ready  <= 1'b0;
         fifo_data_s <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         burst_cnt   <= '0;
         cur_addr    <= '0;
         rem_beats   <= '0;
         beats       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               desc_ready <= 1'b1;
               if (accept) begin
                  desc_ready <= 1'b0;
                  cur_addr   <= desc_addr;
                  rem_beats  <= desc_len[LEN_WID-1:OFF_W];
                  err        <= misalign;
                  burst_cnt  <= '0;
                  if (misalign || desc_len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state <= CALC;
                     busy  <= 1'b1;
                  end
               end
            end
            CALC: begin
               if (abort) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  beats       <= calc_beats;
                  fifo_data_s <= {cur_addr, 24'b0, 8'(calc_beats - 1'b1)};
                  state       <= PUSH;
               end
            end
            PUSH: begin
               if (!fifo_full_s) begin
                  cur_addr  <= cur_addr + (32'(beats) << OFF_W);
                  rem_beats <= rem_beats - REM_W'(beats);
                  burst_cnt <= burst_cnt + 16'd1;
               end
               // An abort on a push cycle still lets that word go out.
               if ((!fifo_full_s && last_push) || abort) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else if (!fifo_full_s) begin
                  state <= CALC;
               end
            end
            DONE: begin
               state      <= IDLE;
               desc_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_idma_rd_burst_split.sv
// Directed bench for idma_rd_burst_split: table of descriptors plus backpressure, abort and reset sequences.
module tb_idma_rd_burst_split;
   logic        clk_s = 1'b0;
   logic        rst_s = 1'b1;
   logic        desc_valid = 1'b0;
   logic        desc_ready;
   logic [31:0] desc_addr = '0;
   logic [31:0] desc_len = '0;
   logic        abort = 1'b0;
   logic        fifo_full_s = 1'b0;
   logic        fifo_push_s;
   logic [63:0] fifo_data_s;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] burst_cnt;

   idma_rd_burst_split #(.BUS_BYTES(8), .MAX_BEATS(16), .LEN_WID(32)) dut (
      .clk_s(clk_s), .rst_s(rst_s), .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_addr(desc_addr), .desc_len(desc_len), .abort(abort), .fifo_full_s(fifo_full_s),
      .fifo_push_s(fifo_push_s), .fifo_data_s(fifo_data_s), .busy(busy), .done(done),
      .err(err), .burst_cnt(burst_cnt)
   );

   always #5 clk_s = ~clk_s;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] len;
      int          n;
      logic        e;
      logic [63:0] first;
      logic [63:0] last;
   } vec_t;

   vec_t        vecs[8];
   int          checks = 0;
   int          errors = 0;
   logic [63:0] q[$];
   int          np, nd;
   logic [15:0] cnt_done;
   logic        bsy_done, rdy_busy;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_reset(input string nm);
      chk({nm, "_desc_ready"}, 64'(desc_ready), 64'd0);
      chk({nm, "_push"}, 64'(fifo_push_s), 64'd0);
      chk({nm, "_data"}, fifo_data_s, 64'd0);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_done"}, 64'(done), 64'd0);
      chk({nm, "_err"}, 64'(err), 64'd0);
      chk({nm, "_burst_cnt"}, 64'(burst_cnt), 64'd0);
   endtask

   // Called at a negedge; returns at the negedge just after the accepting posedge.
   task automatic send(input logic [31:0] a, input logic [31:0] l);
      int t = 0;
      desc_addr  = a;
      desc_len   = l;
      desc_valid = 1'b1;
      while (!desc_ready && t < 20) begin
         @(negedge clk_s);
         t++;
      end
      chk("accept_timeout", 64'(t < 20), 64'd1);
      @(negedge clk_s);
      desc_valid = 1'b0;
   endtask

   // Samples at negedges until 3 cycles past the first done pulse; optional one-cycle abort.
   task automatic collect(input int abort_at, input bit coincide);
      int cyc = 0;
      int done_cyc = -1;
      bit aborted = 0;
      q.delete();
      np = 0;
      nd = 0;
      cnt_done = 16'hFFFF;
      bsy_done = 1'b1;
      rdy_busy = desc_ready;
      while (cyc < 300) begin
         if (abort) abort = 1'b0;
         if (fifo_push_s) begin
            q.push_back(fifo_data_s);
            np++;
            if (abort_at == np && coincide && !aborted) begin
               abort = 1'b1;
               aborted = 1;
            end
         end else if (abort_at > 0 && abort_at == np && !coincide && !aborted) begin
            abort = 1'b1;
            aborted = 1;
         end
         if (done) begin
            nd++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               cnt_done = burst_cnt;
               bsy_done = busy;
            end
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
         @(negedge clk_s);
         cyc++;
      end
      abort = 1'b0;
      chk("done_timeout", 64'(done_cyc >= 0), 64'd1);
   endtask

   task automatic verify(input string nm, input int n_exp, input logic e_exp,
                         input logic [63:0] f_exp, input logic [63:0] l_exp,
                         input logic [31:0] len, input bit full_len);
      int sum = 0;
      int bad = 0;
      chk({nm, "_pushes"}, 64'(np), 64'(n_exp));
      chk({nm, "_done_pulses"}, 64'(nd), 64'd1);
      chk({nm, "_burst_cnt"}, 64'(cnt_done), 64'(n_exp));
      chk({nm, "_busy_at_done"}, 64'(bsy_done), 64'd0);
      chk({nm, "_ready_while_busy"}, 64'(rdy_busy), 64'd0);
      chk({nm, "_err"}, 64'(err), 64'(e_exp));
      if (n_exp > 0 && q.size() > 0) begin
         chk({nm, "_first"}, q[0], f_exp);
         chk({nm, "_last"}, q[q.size()-1], l_exp);
      end
      if (full_len) begin
         foreach (q[i]) begin
            int b;
            int lo;
            b = int'(q[i][7:0]) + 1;
            lo = int'(q[i][43:32]);
            sum += b * 8;
            if (lo + b * 8 > 4096 || b > 16 || q[i][31:8] != 24'd0) bad++;
         end
         chk({nm, "_bytes"}, 64'(sum), e_exp ? 64'd0 : 64'(len));
         chk({nm, "_burst_legal"}, 64'(bad), 64'd0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"aligned_short", 32'h1000, 32'd64,   1,  1'b0, 64'h00001000_00000007, 64'h00001000_00000007};
      vecs[1] = '{"cross_4k",      32'h0FF0, 32'd64,   2,  1'b0, 64'h00000FF0_00000001, 64'h00001000_00000005};
      vecs[2] = '{"max_split",     32'h2000, 32'd2400, 19, 1'b0, 64'h00002000_0000000F, 64'h00002900_0000000B};
      vecs[3] = '{"misalign_addr", 32'h1004, 32'd64,   0,  1'b1, 64'd0, 64'd0};
      vecs[4] = '{"zero_len",      32'h1000, 32'd0,    0,  1'b0, 64'd0, 64'd0};
      vecs[5] = '{"misalign_len",  32'h1000, 32'd12,   0,  1'b1, 64'd0, 64'd0};
      vecs[6] = '{"near_4k_multi", 32'h0FC0, 32'h200,  5,  1'b0, 64'h00000FC0_00000007, 64'h00001180_00000007};
      vecs[7] = '{"one_beat_edge", 32'h0FF8, 32'd8,    1,  1'b0, 64'h00000FF8_00000000, 64'h00000FF8_00000000};

      repeat (2) @(negedge clk_s);
      check_reset("por");
      rst_s = 1'b0;
      @(negedge clk_s);

      for (int i = 0; i < 8; i++) begin
         send(vecs[i].addr, vecs[i].len);
         collect(0, 0);
         verify(vecs[i].name, vecs[i].n, vecs[i].e, vecs[i].first, vecs[i].last, vecs[i].len, 1);
      end

      // Backpressure: FIFO full for 5 PUSH cycles, then released.
      fifo_full_s = 1'b1;
      send(32'h2000, 32'd2400);
      @(negedge clk_s);
      for (int i = 0; i < 5; i++) begin
         chk("bp_no_push", 64'(fifo_push_s), 64'd0);
         chk("bp_data_stable", fifo_data_s, 64'h00002000_0000000F);
         @(negedge clk_s);
      end
      fifo_full_s = 1'b0;
      #1;
      chk("bp_push_after_release", 64'(fifo_push_s), 64'd1);
      collect(0, 0);
      verify("bp", 19, 1'b0, 64'h00002000_0000000F, 64'h00002900_0000000B, 32'd2400, 1);
      for (int i = 0; i < 18 && i < q.size(); i++)
         chk("bp_seq", q[i], {32'h2000 + 32'(i) * 32'h80, 32'h0000000F});

      // Abort one cycle after the 3rd push (CALC), then abort coinciding with the 4th push.
      send(32'h2000, 32'd2400);
      collect(3, 0);
      verify("abort_calc", 3, 1'b0, 64'h00002000_0000000F, 64'h00002100_0000000F, 32'd0, 0);
      send(32'h2000, 32'd2400);
      collect(4, 1);
      verify("abort_push", 4, 1'b0, 64'h00002000_0000000F, 64'h00002180_0000000F, 32'd0, 0);

      // Abort while idle must not start anything.
      abort = 1'b1;
      @(negedge clk_s);
      abort = 1'b0;
      chk("idle_abort_ready", 64'(desc_ready), 64'd1);
      chk("idle_abort_busy", 64'(busy), 64'd0);
      chk("idle_abort_done", 64'(done), 64'd0);
      @(negedge clk_s);
      chk("idle_abort_done2", 64'(done), 64'd0);

      // Asynchronous reset in the middle of PUSH.
      begin
         int seen = 0;
         int t = 0;
         send(32'h2000, 32'd2400);
         while (seen < 2 && t < 100) begin
            @(negedge clk_s);
            t++;
            if (fifo_push_s) seen++;
         end
         chk("rst_reach_push", 64'(seen), 64'd2);
         #2 rst_s = 1'b1;
         #1;
         check_reset("midrst");
         @(negedge clk_s);
         rst_s = 1'b0;
         @(negedge clk_s);
         send(32'h1000, 32'd64);
         collect(0, 0);
         verify("after_rst", 1, 1'b0, 64'h00001000_00000007, 64'h00001000_00000007, 32'd64, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
